// File: rtl/qr_tx_sequencer.sv
// Streams a latched QR decode result to a UART byte by byte, with an optional
// terminator, length clamping and rejection of non-byte-mode results.
module qr_tx_sequencer #(
  parameter int         MAX_BYTES = 17,
  parameter int         SEND_TERM = 1,
  parameter logic [7:0] TERM_BYTE = 8'h0A,
  parameter logic [3:0] BYTE_MODE = 4'b0100
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [3:0]   data_type_in,
  input  logic [7:0]   data_length_in,
  input  logic [151:0] bytes_in,
  input  logic         tx_ready_in,
  output logic [7:0]   tx_data_out,
  output logic         tx_valid_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         err_out,
  output logic         trunc_out
);

  typedef enum logic [2:0] {IDLE, CHECK, SEND, TERM, FIN} state_e;

  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);
  localparam logic [4:0] MAX_CNT = 5'(MAX_BYTES);

  state_e            state_q, state_d;
  logic [3:0]        type_q, type_d;
  logic [7:0]        len_q, len_d;
  logic [18:0][7:0]  bytes_q, bytes_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              trunc_q, trunc_d;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    len_d   = len_q;
    bytes_d = bytes_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          type_d  = data_type_in;
          len_d   = data_length_in;
          bytes_d = bytes_in;
          trunc_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (type_q != BYTE_MODE) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (len_q == 8'd0) begin
          state_d = (SEND_TERM != 0) ? TERM : FIN;
        end else begin
          cnt_d   = (len_q > MAX_LEN) ? MAX_CNT : len_q[4:0];
          trunc_d = (len_q > MAX_LEN);
          idx_d   = 5'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready_in) begin
          if (idx_q == cnt_q - 5'd1) state_d = (SEND_TERM != 0) ? TERM : FIN;
          else                       idx_d   = idx_q + 5'd1;
        end
      end
      TERM: begin
        if (tx_ready_in) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so every output is a flop that
    // already reflects the state being entered.
    tx_valid_d = (state_d == SEND) || (state_d == TERM);
    tx_data_d  = (state_d == SEND) ? bytes_q[idx_d] :
                 (state_d == TERM) ? TERM_BYTE : 8'h00;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      type_q     <= '0;
      len_q      <= '0;
      bytes_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      len_q      <= len_d;
      bytes_q    <= bytes_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      trunc_q    <= trunc_d;
    end
  end

  assign tx_data_out  = tx_data_q;
  assign tx_valid_out = tx_valid_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign err_out      = err_q;
  assign trunc_out    = trunc_q;

endmodule

// File: tb/tb_qr_tx_sequencer.sv
// Bench for qr_tx_sequencer: table of directed requests, reset corner cases,
// then random requests checked against a byte-list reference model.
module tb_qr_tx_sequencer;

  logic         clk_in = 1'b0;
  logic         rst_in, start_in, tx_ready_in;
  logic [3:0]   data_type_in;
  logic [7:0]   data_length_in;
  logic [151:0] bytes_in;
  logic [7:0]   tx_data_out;
  logic         tx_valid_out, busy_out, done_out, err_out, trunc_out;

  qr_tx_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .data_type_in(data_type_in), .data_length_in(data_length_in),
    .bytes_in(bytes_in), .tx_ready_in(tx_ready_in),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
    .trunc_out(trunc_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the list of bytes the UART should see, built from the rules.
  function automatic void model(input logic [3:0] t, input logic [7:0] l,
                                input logic [151:0] b, output bit err, output bit trunc);
    int n;
    exp_q.delete();
    err   = (t != 4'b0100);
    trunc = !err && (l > 8'd17);
    if (!err) begin
      n = (l > 8'd17) ? 17 : int'(l);
      for (int k = 0; k < n; k++) exp_q.push_back(b[8*k +: 8]);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic logic [151:0] rand_bytes();
    logic [151:0] r;
    for (int k = 0; k < 19; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic logic [151:0] pat_bytes(input logic [7:0] seed);
    logic [151:0] r;
    for (int k = 0; k < 19; k++) r[8*k +: 8] = seed + 8'(13 * k);
    return r;
  endfunction

  // Called and returns at posedge+1. rmode: 0 ready=1, 1 pattern 1,0,0, 2 random.
  task automatic run_req(input logic [3:0] t, input logic [7:0] l, input logic [151:0] b,
                         input int rmode, input bit poke,
                         output int nx, output int done_c, output bit err_o, output bit trunc_o);
    bit m_err, m_trunc, fin, pv, px;
    logic [7:0] pd;
    int c, last_x, first_v;
    model(t, l, b, m_err, m_trunc);
    got_q.delete();
    data_type_in = t; data_length_in = l; bytes_in = b; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    data_type_in = 4'($urandom); data_length_in = 8'($urandom); bytes_in = rand_bytes();
    c = 1; nx = 0; fin = 0; pv = 0; px = 0; pd = 8'h00;
    done_c = -1; err_o = 0; last_x = -1; first_v = -1;
    while (!fin && c < 400) begin
      if (c == 1) begin
        chk("check_busy", 32'(busy_out), 1);
        chk("check_novalid", 32'(tx_valid_out), 0);
        chk("trunc_cleared", 32'(trunc_out), 0);
      end
      if (pv && !px) begin
        chk("hold_valid", 32'(tx_valid_out), 1);
        chk("hold_data", 32'(tx_data_out), 32'(pd));
      end
      case (rmode)
        0:       tx_ready_in = 1'b1;
        1:       tx_ready_in = ((c - 2) % 3 == 0);
        default: tx_ready_in = 1'($urandom_range(0, 1));
      endcase
      start_in = poke && (c == 3);
      if (tx_valid_out && first_v < 0) first_v = c;
      if (tx_valid_out && tx_ready_in) begin
        if (nx < exp_q.size()) chk($sformatf("xfer%0d", nx), 32'(tx_data_out), 32'(exp_q[nx]));
        else chk("extra_xfer", 32'(nx + 1), 32'(exp_q.size()));
        got_q.push_back(tx_data_out);
        nx++; last_x = c;
      end
      if (done_out) begin fin = 1; done_c = c; err_o = err_out; end
      pv = tx_valid_out; px = tx_valid_out && tx_ready_in; pd = tx_data_out;
      @(posedge clk_in); #1; c++;
    end
    start_in = 1'b0;
    chk("done_seen", 32'(fin), 1);
    chk("xfer_count", 32'(nx), 32'(exp_q.size()));
    chk("err_flag", 32'(err_o), 32'(m_err));
    if (fin) chk("done_latency", 32'(done_c), (exp_q.size() == 0) ? 32'd2 : 32'(last_x + 1));
    chk("first_valid", 32'(first_v), (exp_q.size() == 0) ? -32'sd1 : 32'd2);
    chk("idle_busy", 32'(busy_out), 0);
    chk("idle_done", 32'(done_out), 0);
    chk("idle_valid", 32'(tx_valid_out), 0);
    chk("trunc_sticky", 32'(trunc_out), 32'(m_trunc));
    trunc_o = trunc_out;
    @(posedge clk_in); #1;
    chk("idle_busy2", 32'(busy_out), 0);
    chk("trunc_sticky2", 32'(trunc_out), 32'(m_trunc));
  endtask

  typedef struct {
    logic [3:0]   t;
    logic [7:0]   l;
    logic [151:0] b;
    int           rmode;
    int           exp_n;
    bit           exp_err;
    bit           exp_trunc;
    int           exp_done;  // -1 when backpressure makes it data dependent
  } vec_t;

  initial begin
    vec_t vecs[9];
    logic [151:0] nom_b;
    logic [7:0] nom[4];
    int nx, dc;
    bit e, tr;

    nom_b = '0;
    nom_b[7:0] = 8'h48; nom_b[15:8] = 8'h69; nom_b[23:16] = 8'h21;
    nom[0] = 8'h48; nom[1] = 8'h69; nom[2] = 8'h21; nom[3] = 8'h0A;
    vecs[0] = '{4'b0100, 8'd3,  nom_b,           0, 4,  0, 0, 6};
    vecs[1] = '{4'b0100, 8'd3,  nom_b,           1, 4,  0, 0, -1};
    vecs[2] = '{4'b0010, 8'd5,  pat_bytes(8'h11), 0, 0,  1, 0, 2};
    vecs[3] = '{4'b0100, 8'd25, pat_bytes(8'h20), 0, 18, 0, 1, 20};
    vecs[4] = '{4'b0100, 8'd0,  pat_bytes(8'h33), 0, 1,  0, 0, 3};
    vecs[5] = '{4'b0100, 8'd17, pat_bytes(8'h44), 0, 18, 0, 0, 20};
    vecs[6] = '{4'b0100, 8'd18, pat_bytes(8'h55), 1, 18, 0, 1, -1};
    vecs[7] = '{4'b1111, 8'd0,  pat_bytes(8'h66), 0, 0,  1, 0, 2};
    vecs[8] = '{4'b0100, 8'd1,  pat_bytes(8'h77), 0, 2,  0, 0, 4};

    rst_in = 1'b1; start_in = 1'b0; tx_ready_in = 1'b0;
    data_type_in = '0; data_length_in = '0; bytes_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", 32'(tx_valid_out), 0);
    chk("rst_data",  32'(tx_data_out), 0);
    chk("rst_busy",  32'(busy_out), 0);
    chk("rst_done",  32'(done_out), 0);
    chk("rst_err",   32'(err_out), 0);
    chk("rst_trunc", 32'(trunc_out), 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    foreach (vecs[i]) begin
      run_req(vecs[i].t, vecs[i].l, vecs[i].b, vecs[i].rmode, 1'b0, nx, dc, e, tr);
      chk($sformatf("tbl%0d_n", i), 32'(nx), 32'(vecs[i].exp_n));
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("tbl%0d_trunc", i), 32'(tr), 32'(vecs[i].exp_trunc));
      if (vecs[i].exp_done >= 0) chk($sformatf("tbl%0d_done", i), 32'(dc), 32'(vecs[i].exp_done));
      if (i <= 1)
        for (int k = 0; k < 4; k++)
          chk($sformatf("tbl%0d_byte%0d", i, k),
              (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD, 32'(nom[k]));
    end

    // Reset after the second transfer of a length-10 request.
    tx_ready_in = 1'b1;
    data_type_in = 4'b0100; data_length_in = 8'd10; bytes_in = pat_bytes(8'h80); start_in = 1'b1;
    @(posedge clk_in); #1; start_in = 1'b0;
    @(posedge clk_in); #1;
    chk("mid_x0", 32'(tx_data_out), 32'h80);
    @(posedge clk_in); #1;
    chk("mid_x1", 32'(tx_data_out), 32'h8D);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk("mid_valid", 32'(tx_valid_out), 0);
    chk("mid_busy", 32'(busy_out), 0);
    chk("mid_done", 32'(done_out), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_in); #1;
      chk("mid_no_done", 32'(done_out), 0);
    end

    // Reset wins over a simultaneous start.
    rst_in = 1'b1; start_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0; start_in = 1'b0;
    chk("rst_vs_start_busy", 32'(busy_out), 0);
    @(posedge clk_in); #1;
    chk("rst_vs_start_busy2", 32'(busy_out), 0);

    // Normal start afterwards, with an extra start poked while busy.
    run_req(4'b0100, 8'd3, pat_bytes(8'h90), 0, 1'b1, nx, dc, e, tr);
    chk("poke_n", 32'(nx), 4);
    chk("poke_done", 32'(dc), 6);

    for (int r = 0; r < 30; r++) begin
      logic [3:0] t;
      logic [7:0] l;
      t = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0100;
      l = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 25));
      run_req(t, l, rand_bytes(), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              nx, dc, e, tr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
